// File: rtl/alu_byte_sequencer.sv
// Byte-serial wrapper around the 8-bit ALU function.
// Loads A, B, opcode as three bytes; returns result and optional flags byte.
module alu_byte_sequencer #(
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       clr,
    output logic       busy
);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        EXEC,
        OUT_RES,
        OUT_FLG
    } state_t;

    state_t     state;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] flags;

    logic [8:0] sum;
    logic [8:0] dif;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_v;
    logic [7:0] alu_flags;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // ALU datapath: result plus carry/borrow and signed overflow
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            3'b000: begin
                alu_res = sum[7:0];
                alu_c   = sum[8];
                alu_v   = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            3'b001: begin
                alu_res = dif[7:0];
                alu_c   = dif[8];
                alu_v   = (a[7] != b[7]) && (dif[7] != a[7]);
            end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a | b;
            3'b100: alu_res = a ^ b;
            3'b101: alu_res = ~(a & b);
            3'b110: alu_res = ~(a | b);
            3'b111: alu_res = ~a;
            default: alu_res = 8'h00;
        endcase
        alu_flags = {4'b0000, alu_v, alu_res[7], alu_c, alu_res == 8'h00};
    end

    // Sequencer FSM with registered handshake outputs; clr beats any handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            a         <= 8'h00;
            b         <= 8'h00;
            op        <= 3'b000;
            flags     <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            busy      <= 1'b0;
        end else if (clr) begin
            state     <= LOAD_A;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (in_xfer) begin
                        a     <= in_data;
                        busy  <= 1'b1;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        b     <= in_data;
                        state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (in_xfer) begin
                        op       <= in_data[2:0];
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    out_data  <= alu_res;
                    flags     <= alu_flags;
                    out_valid <= 1'b1;
                    state     <= OUT_RES;
                end
                OUT_RES: begin
                    if (out_xfer) begin
                        if (FLAGS_EN) begin
                            out_data <= flags;
                            state    <= OUT_FLG;
                        end else begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= LOAD_A;
                        end
                    end
                end
                OUT_FLG: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Bench for alu_byte_sequencer: two instances (flags on/off) checked
// every cycle against a transaction-level model, plus literal results.
module tb_alu_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [1:0]  bz;
    logic [15:0] odp;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit log_en = 1'b1;

    logic [7:0] log0[$];
    logic [7:0] log1[$];

    // model state per instance: bytes loaded, exec pending, output bytes left
    int         m_cnt[2];
    bit         m_exec[2];
    int         m_left[2];
    int         m_pos[2];
    logic [7:0] m_a[2];
    logic [7:0] m_b[2];
    logic [7:0] m_out[2][2];

    alu_byte_sequencer #(.FLAGS_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[0]), .out_data(odp[7:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .clr(clr), .busy(bz[0])
    );

    alu_byte_sequencer #(.FLAGS_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[1]), .out_data(odp[15:8]), .out_valid(ov[1]),
        .out_ready(out_ready), .clr(clr), .busy(bz[1])
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [2:0] op);
        int u;
        int s;
        logic [7:0] r;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        r = 8'h00;
        case (op)
            3'd0: begin
                u = int'(a) + int'(b);
                r = u[7:0];
                c = (u > 255);
                s = int'($signed(a)) + int'($signed(b));
                v = (s > 127) || (s < -128);
            end
            3'd1: begin
                u = int'(a) - int'(b);
                r = u[7:0];
                c = (a < b);
                s = int'($signed(a)) - int'($signed(b));
                v = (s > 127) || (s < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = ~a;
        endcase
        return {4'b0000, v, r[7], c, (r == 8'h00), r};
    endfunction

    function automatic logic [7:0] ref_byte(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] opb,
                                            input bit flg);
        logic [15:0] t;
        t = alu_ref(a, b, opb[2:0]);
        return flg ? t[15:8] : t[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model advances on the same edges as the design
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || clr) begin
                m_cnt[d]  <= 0;
                m_exec[d] <= 1'b0;
                m_left[d] <= 0;
                m_pos[d]  <= 0;
            end else if (m_exec[d]) begin
                m_exec[d] <= 1'b0;
                m_left[d] <= (d == 0) ? 2 : 1;
                m_pos[d]  <= 0;
            end else if (m_left[d] != 0) begin
                if (out_ready) begin
                    m_pos[d]  <= m_pos[d] + 1;
                    m_left[d] <= m_left[d] - 1;
                end
            end else if (in_valid) begin
                if (m_cnt[d] == 0) m_a[d] <= in_data;
                else if (m_cnt[d] == 1) m_b[d] <= in_data;
                else begin
                    m_out[d][0] <= ref_byte(m_a[d], m_b[d], in_data, 1'b0);
                    m_out[d][1] <= ref_byte(m_a[d], m_b[d], in_data, 1'b1);
                    m_exec[d]   <= 1'b1;
                end
                m_cnt[d] <= (m_cnt[d] == 2) ? 0 : m_cnt[d] + 1;
            end
        end
    end

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("in_ready%0d", d), 32'(ir[d]),
                    32'(!m_exec[d] && m_left[d] == 0));
                chk($sformatf("out_valid%0d", d), 32'(ov[d]),
                    32'(m_left[d] != 0));
                chk($sformatf("busy%0d", d), 32'(bz[d]),
                    32'(m_cnt[d] != 0 || m_exec[d] || m_left[d] != 0));
                if (m_left[d] != 0)
                    chk($sformatf("out_data%0d", d),
                        32'(d == 0 ? odp[7:0] : odp[15:8]),
                        32'(m_out[d][m_pos[d]]));
            end
        end
    end

    // record every output byte that is about to transfer
    always @(negedge clk) begin
        if (log_en && !rst && !clr && out_ready) begin
            if (ov[0]) log0.push_back(odp[7:0]);
            if (ov[1]) log1.push_back(odp[15:8]);
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!ir[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_log(input int d, input int n,
                              input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] q[$];
        q = (d == 0) ? log0 : log1;
        chk($sformatf("log%0d_len", d), 32'(q.size()), 32'(n));
        if (n > 0 && q.size() > 0) chk($sformatf("log%0d_b0", d), 32'(q[0]), 32'(e0));
        if (n > 1 && q.size() > 1) chk($sformatf("log%0d_b1", d), 32'(q[1]), 32'(e1));
        if (d == 0) log0.delete();
        else log1.delete();
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] r,
                          input logic [7:0] f);
        send(a);
        send(b);
        send(op);
        idle(4);
        expect_log(0, 2, r, f);
        expect_log(1, 1, r, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_out_data", 32'(odp), 32'h0);
        chk("rst_out_valid", 32'(ov), 32'h0);
        chk("rst_in_ready", 32'(ir), 32'h3);
        chk("rst_busy", 32'(bz), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // ADD with overflow, plus result latency
        send(8'h7F);
        send(8'h01);
        send(8'h00);
        chk("lat_exec_valid", 32'(ov[0]), 32'h0);
        @(negedge clk);
        chk("lat_res_valid", 32'(ov[0]), 32'h1);
        chk("lat_res_data", 32'(odp[7:0]), 32'h80);
        idle(3);
        expect_log(0, 2, 8'h80, 8'h0C);
        expect_log(1, 1, 8'h80, 8'h00);

        run_op(8'hFF, 8'h01, 8'h00, 8'h00, 8'h03);
        run_op(8'h10, 8'h20, 8'h01, 8'hF0, 8'h06);
        run_op(8'hF0, 8'h0F, 8'hFA, 8'h00, 8'h01);

        // backpressure in the result phase
        out_ready = 1'b0;
        send(8'h7F);
        send(8'h01);
        send(8'h00);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(ov), 32'h3);
            chk("bp_data0", 32'(odp[7:0]), 32'h80);
            chk("bp_data1", 32'(odp[15:8]), 32'h80);
            chk("bp_in_ready", 32'(ir), 32'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_flg_valid", 32'(ov[0]), 32'h1);
        chk("bp_flg_data", 32'(odp[7:0]), 32'h0C);
        chk("bp_nf_valid", 32'(ov[1]), 32'h0);
        chk("bp_nf_ready", 32'(ir[1]), 32'h1);
        idle(3);
        expect_log(0, 2, 8'h80, 8'h0C);
        expect_log(1, 1, 8'h80, 8'h00);

        // abort after two operands, then NOT
        send(8'h11);
        send(8'h22);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", 32'(bz), 32'h0);
        idle(4);
        expect_log(0, 0, 8'h00, 8'h00);
        expect_log(1, 0, 8'h00, 8'h00);
        run_op(8'h05, 8'h03, 8'h07, 8'hFA, 8'h04);

        // asynchronous reset while the result is pending
        out_ready = 1'b0;
        send(8'h12);
        send(8'h34);
        send(8'h00);
        @(negedge clk);
        chk("pre_rst_valid", 32'(ov[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ov), 32'h0);
        chk("arst_in_ready", 32'(ir), 32'h3);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        log0.delete();
        log1.delete();

        // idle gaps between bytes; in_valid held during exec/output
        send(8'h3C);
        idle(2);
        send(8'h0F);
        idle(1);
        send(8'h04);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        idle(3);
        in_valid = 1'b0;
        idle(2);
        expect_log(0, 2, 8'h33, 8'h00);
        expect_log(1, 1, 8'h33, 8'h00);
        chk("gap_ready0", 32'(ir[0]), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // randomized traffic, checked by the model every cycle
        log_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        clr = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
